mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares the single `memory` instance between the core (fetch and memory-stage accesses) and a debug/loader port. It latches one request at a time and drives a stable request to memory until the access completes. It returns the read data and fault status to the winning requester with a one-cycle acknowledge. Round-robin fairness, alignment checking and a completion timeout are handled here, so neither requester can wedge the memory.

## Interface
- `TIMEOUT`, 16: maximum number of BUSY cycles allowed for `m_done` before the access is aborted with a fault. Must be ≥ 1; the counter is `$clog2(TIMEOUT+1)` bits wide.
- `clk` in, 1: the single clock; all state updates on the rising edge.
- `reset` in, 1: synchronous, active-low. When low at a rising edge, all state returns to reset values.
- `c_req`, `c_we`, `c_unsigned` in, 1 each: core request, write enable, and zero-extend-loads flag.
- `c_size` in, 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `c_addr`, `c_wdata` in, 32 each: core address and store data.
- `c_ack` out, 1: one-cycle completion pulse to the core.
- `c_rdata` out, 32: read data to the core; valid only while `c_ack` is high.
- `c_fault` out, 1: fault status to the core; valid only while `c_ack` is high.
- `d_req`, `d_we`, `d_unsigned`, `d_size`, `d_addr`, `d_wdata`, `d_ack`, `d_rdata`, `d_fault`: debug port, identical semantics to the core port.
- `m_valid` out, 1: request to memory; held high for the whole access.
- `m_we`, `m_unsigned` out, 1 each; `m_size` out, 2; `m_addr`, `m_wdata` out, 32 each: latched request fields.
- `m_done` in, 1: memory completion; sampled only in BUSY.
- `m_rdata` in, 32; `m_fault` in, 1: memory results; sampled only on the edge where `m_done` is high.

## Operation
- States:
  - IDLE: no transaction in progress.
  - BUSY: a transaction is in flight and `m_valid` is high.
  - ACK: the requester's ack is asserted for one cycle.
- In IDLE with any `*_req` high, the arbiter selects the winner:
  - If only one request is high, that requester wins.
  - If both are high, the requester that was not the last winner wins.
  - `last` resets to debug, so the core wins the first tie.
  - `last` is updated on every acceptance, including aborted and misaligned accesses.
- On acceptance, the winner's `we`/`size`/`unsigned`/`addr`/`wdata` are latched.
  - The outputs come from these registers, not from the live inputs.
  - Changes to the requester's inputs after acceptance are ignored.
- Alignment check at acceptance:
  - Faulting cases: size 11; half with `addr[0]` = 1; word with `addr[1:0]` ≠ 0.
  - A faulting access goes IDLE→ACK directly with fault = 1 and rdata = 0.
  - `m_valid` is never raised for a misaligned access.
- Legal accesses go IDLE→BUSY.
  - `m_valid` = 1 and the timeout counter clears to 0.
  - The counter increments once per BUSY cycle.
- BUSY, `m_done` high at an edge:
  - Register `m_rdata` → winner's rdata and `m_fault` → winner's fault.
  - Go to ACK; `m_valid` = 0.
- BUSY, `m_done` low and counter = `TIMEOUT`-1:
  - Go to ACK with fault = 1 and rdata = 0; `m_valid` = 0.
  - A later `m_done` is ignored.
- ACK: the winner's ack = 1 for exactly one cycle, then IDLE.
  - `*_req` is ignored during ACK.
  - A requester must drop `req` in its ACK cycle. A `req` still high in IDLE is treated as a new request.
- Writes return rdata = 0. Fault on writes comes from `m_fault`, the alignment check, or timeout.
- The non-winning port's ack/rdata/fault remain 0 throughout.

## Timing
- Reset values: state = IDLE and `last` = debug; all of the following are 0: counter, `m_valid`, `m_we`, `m_unsigned`, `m_size`, `m_addr`, `m_wdata`, `c_ack`, `c_rdata`, `c_fault`, `d_ack`, `d_rdata`, `d_fault`.
- Reset mid-transaction:
  - Aborts the access with no ack.
  - `m_valid` is low in the cycle after the reset edge.
- Request high in cycle n → `m_valid` high in cycle n+1.
- `m_done` high in cycle k → ack in cycle k+1 → IDLE in cycle k+2.
- Minimum legal access is 3 cycles per transaction: BUSY 1, ACK 1, IDLE 1.
- Misaligned access: ack in cycle n+1.
- Timeout: ack in cycle n+1+`TIMEOUT`. BUSY lasts exactly `TIMEOUT` cycles.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Core-only load:
  - Stimulus: `c_req` = 1, size 10, addr 0x100; memory returns `m_done` 2 cycles after `m_valid` with rdata 0xDEADBEEF.
  - Expected: `m_addr` = 0x100 and `m_size` = 10 held stable across BUSY; `c_ack` pulses one cycle with `c_rdata` = 0xDEADBEEF and `c_fault` = 0; `d_ack` stays 0.
- Simultaneous requests:
  - Stimulus: `c_req` and `d_req` both held high through 4 back-to-back accesses.
  - Expected: grant order core, debug, core, debug; each ack lands 3 cycles after the previous one when `m_done` returns immediately.
- Misaligned access:
  - Stimulus: debug half-word write at addr 0x3.
  - Expected: `m_valid` never rises; `d_ack` = 1 with `d_fault` = 1 one cycle after the request.
  - Follow-up: size 11 at addr 0x0 produces the same result.
- Timeout:
  - Stimulus: `TIMEOUT` = 4; `m_done` tied low.
  - Expected: `m_valid` is high for exactly 4 cycles, then `c_ack` = 1 with `c_fault` = 1 and `c_rdata` = 0.
  - Follow-up: a late `m_done` pulse in IDLE has no effect.
- Input change after acceptance:
  - Stimulus: `c_addr` changes from 0x10 to 0x20 during BUSY.
  - Expected: `m_addr` stays 0x10.
- Memory fault passthrough:
  - Stimulus: `m_fault` = 1 with `m_done`.
  - Expected: `c_fault` = 1.
- Reset mid-BUSY:
  - Stimulus: `reset` low for one edge during BUSY.
  - Expected: all outputs 0 the next cycle; no ack; the next simultaneous request is granted to the core.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one memory port between the core and the debug/loader requester.
// Round-robin on ties, alignment rejection, and a BUSY timeout so no requester can wedge memory.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic        c_unsigned,
  input  logic [1:0]  c_size,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_ack,
  output logic [31:0] c_rdata,
  output logic        c_fault,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_unsigned,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_fault,
  output logic        m_valid,
  output logic        m_we,
  output logic        m_unsigned,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_done,
  input  logic [31:0] m_rdata,
  input  logic        m_fault
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t state, state_nxt;
  logic             last_d, last_d_nxt;
  logic             win_d, win_d_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic        m_valid_nxt, m_we_nxt, m_unsigned_nxt;
  logic [1:0]  m_size_nxt;
  logic [31:0] m_addr_nxt, m_wdata_nxt;
  logic        c_ack_nxt, c_fault_nxt, d_ack_nxt, d_fault_nxt;
  logic [31:0] c_rdata_nxt, d_rdata_nxt;

  // Debug wins only if core is idle or core won last time.
  logic        sel_d;
  logic        req_we, req_unsigned, misaligned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  assign sel_d        = d_req & (~c_req | ~last_d);
  assign req_we       = sel_d ? d_we       : c_we;
  assign req_unsigned = sel_d ? d_unsigned : c_unsigned;
  assign req_size     = sel_d ? d_size     : c_size;
  assign req_addr     = sel_d ? d_addr     : c_addr;
  assign req_wdata    = sel_d ? d_wdata    : c_wdata;
  assign misaligned   = (req_size == 2'b11) ||
                        (req_size == 2'b01 && req_addr[0]) ||
                        (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  always_comb begin
    state_nxt      = state;
    last_d_nxt     = last_d;
    win_d_nxt      = win_d;
    cnt_nxt        = cnt;
    m_valid_nxt    = m_valid;
    m_we_nxt       = m_we;
    m_unsigned_nxt = m_unsigned;
    m_size_nxt     = m_size;
    m_addr_nxt     = m_addr;
    m_wdata_nxt    = m_wdata;
    c_ack_nxt      = 1'b0;
    c_rdata_nxt    = 32'h0;
    c_fault_nxt    = 1'b0;
    d_ack_nxt      = 1'b0;
    d_rdata_nxt    = 32'h0;
    d_fault_nxt    = 1'b0;

    unique case (state)
      IDLE: begin
        if (c_req || d_req) begin
          win_d_nxt      = sel_d;
          last_d_nxt     = sel_d;
          m_we_nxt       = req_we;
          m_unsigned_nxt = req_unsigned;
          m_size_nxt     = req_size;
          m_addr_nxt     = req_addr;
          m_wdata_nxt    = req_wdata;
          if (misaligned) begin
            state_nxt   = ACK;
            c_ack_nxt   = ~sel_d;
            c_fault_nxt = ~sel_d;
            d_ack_nxt   = sel_d;
            d_fault_nxt = sel_d;
          end else begin
            state_nxt   = BUSY;
            m_valid_nxt = 1'b1;
            cnt_nxt     = '0;
          end
        end
      end
      BUSY: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (m_done) begin
          state_nxt   = ACK;
          m_valid_nxt = 1'b0;
          c_ack_nxt   = ~win_d;
          d_ack_nxt   = win_d;
          c_fault_nxt = ~win_d & m_fault;
          d_fault_nxt = win_d & m_fault;
          c_rdata_nxt = (~win_d & ~m_we) ? m_rdata : 32'h0;
          d_rdata_nxt = (win_d & ~m_we) ? m_rdata : 32'h0;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_nxt   = ACK;
          m_valid_nxt = 1'b0;
          c_ack_nxt   = ~win_d;
          d_ack_nxt   = win_d;
          c_fault_nxt = ~win_d;
          d_fault_nxt = win_d;
        end
      end
      ACK: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      last_d     <= 1'b1;
      win_d      <= 1'b0;
      cnt        <= '0;
      m_valid    <= 1'b0;
      m_we       <= 1'b0;
      m_unsigned <= 1'b0;
      m_size     <= 2'b00;
      m_addr     <= 32'h0;
      m_wdata    <= 32'h0;
      c_ack      <= 1'b0;
      c_rdata    <= 32'h0;
      c_fault    <= 1'b0;
      d_ack      <= 1'b0;
      d_rdata    <= 32'h0;
      d_fault    <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_d     <= last_d_nxt;
      win_d      <= win_d_nxt;
      cnt        <= cnt_nxt;
      m_valid    <= m_valid_nxt;
      m_we       <= m_we_nxt;
      m_unsigned <= m_unsigned_nxt;
      m_size     <= m_size_nxt;
      m_addr     <= m_addr_nxt;
      m_wdata    <= m_wdata_nxt;
      c_ack      <= c_ack_nxt;
      c_rdata    <= c_rdata_nxt;
      c_fault    <= c_fault_nxt;
      d_ack      <= d_ack_nxt;
      d_rdata    <= d_rdata_nxt;
      d_fault    <= d_fault_nxt;
    end
  end

endmodule
